// File: rtl/ccr_unit.sv
// Condition-code register with a 2-deep flag save stack
// for interrupt entry/return, plus sticky stack error bits.
module ccr_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic [2:0] alu_flags,
    input  logic       flag_wr_en,
    input  logic [2:0] flag_wr_mask,
    input  logic       set_c,
    input  logic       clr_c,
    input  logic       branch_taken,
    input  logic [1:0] jmp_type,
    input  logic       int_save,
    input  logic       rti_restore,
    output logic [3:0] ccr,
    output logic [1:0] depth,
    output logic       ovf_err,
    output logic       unf_err
);

    logic [2:0] flags_q, flags_d;
    logic [2:0] stk0_q, stk0_d;
    logic [2:0] stk1_q, stk1_d;
    logic [1:0] depth_q, depth_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic [2:0] upd;
    logic       full;

    assign full = depth_q[1];

    // Next-state: restore has priority; otherwise flag update plus optional push
    always_comb begin
        flags_d = flags_q;
        stk0_d  = stk0_q;
        stk1_d  = stk1_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        upd     = flags_q;
        if (!stall) begin
            if (rti_restore) begin
                if (depth_q != 2'd0) begin
                    flags_d = full ? stk1_q : stk0_q;
                    depth_d = depth_q - 2'd1;
                end else begin
                    unf_d = 1'b1;
                end
            end else begin
                if (flag_wr_en) begin
                    upd = (upd & ~flag_wr_mask)
                        | (alu_flags & flag_wr_mask);
                end
                if (clr_c) begin
                    upd[2] = 1'b0;
                end else if (set_c) begin
                    upd[2] = 1'b1;
                end
                if (branch_taken) begin
                    unique case (jmp_type)
                        2'b00:   upd[0] = 1'b0;
                        2'b01:   upd[1] = 1'b0;
                        2'b10:   upd[2] = 1'b0;
                        default: upd = upd;
                    endcase
                end
                flags_d = upd;
                // The pushed value is the pre-update register contents
                if (int_save) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        if (depth_q == 2'd0) begin
                            stk0_d = flags_q;
                        end else begin
                            stk1_d = flags_q;
                        end
                        depth_d = depth_q + 2'd1;
                    end
                end
            end
        end
    end

    // State registers; reset clears everything including saved entries
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
            stk0_q  <= 3'b000;
            stk1_q  <= 3'b000;
            depth_q <= 2'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            stk0_q  <= stk0_d;
            stk1_q  <= stk1_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ccr     = {1'b0, flags_q};
    assign depth   = depth_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Bench for ccr_unit: directed vector table followed by
// randomized traffic checked against a queue-based model.
module tb_ccr_unit;

    logic       clk = 1'b0;
    logic       rst, stall;
    logic [2:0] alu_flags;
    logic       flag_wr_en;
    logic [2:0] flag_wr_mask;
    logic       set_c, clr_c, branch_taken;
    logic [1:0] jmp_type;
    logic       int_save, rti_restore;
    logic [3:0] ccr;
    logic [1:0] depth;
    logic       ovf_err, unf_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ccr_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .alu_flags(alu_flags), .flag_wr_en(flag_wr_en),
        .flag_wr_mask(flag_wr_mask), .set_c(set_c), .clr_c(clr_c),
        .branch_taken(branch_taken), .jmp_type(jmp_type),
        .int_save(int_save), .rti_restore(rti_restore),
        .ccr(ccr), .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    typedef struct {
        bit       rst, stall, wr;
        bit [2:0] mask, alu;
        bit       setc, clrc, br;
        bit [1:0] jt;
        bit       isave, rti;
        bit [3:0] e_ccr;
        bit [1:0] e_depth;
        bit       e_ovf, e_unf;
    } vec_t;

    vec_t tv[$];

    // model state: individual flags and a LIFO of saved {C,N,Z}
    bit       mz, mn, mc, movf, munf;
    bit [2:0] mstk[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        rst          = v.rst;
        stall        = v.stall;
        flag_wr_en   = v.wr;
        flag_wr_mask = v.mask;
        alu_flags    = v.alu;
        set_c        = v.setc;
        clr_c        = v.clrc;
        branch_taken = v.br;
        jmp_type     = v.jt;
        int_save     = v.isave;
        rti_restore  = v.rti;
    endtask

    function automatic vec_t mk(
        bit r, bit s, bit w, bit [2:0] m, bit [2:0] a,
        bit sc, bit cc, bit b, bit [1:0] j, bit is, bit rt,
        bit [3:0] ec, bit [1:0] ed, bit eo, bit eu);
        vec_t v;
        v.rst = r; v.stall = s; v.wr = w; v.mask = m; v.alu = a;
        v.setc = sc; v.clrc = cc; v.br = b; v.jt = j;
        v.isave = is; v.rti = rt;
        v.e_ccr = ec; v.e_depth = ed; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic model_step(vec_t v);
        bit [2:0] old;
        if (v.rst) begin
            {mc, mn, mz} = 3'b000;
            movf = 0;
            munf = 0;
            mstk.delete();
        end else if (!v.stall) begin
            if (v.rti) begin
                if (mstk.size() > 0) {mc, mn, mz} = mstk.pop_back();
                else munf = 1;
            end else begin
                old = {mc, mn, mz};
                if (v.wr) begin
                    if (v.mask[0]) mz = v.alu[0];
                    if (v.mask[1]) mn = v.alu[1];
                    if (v.mask[2]) mc = v.alu[2];
                end
                if (v.clrc) mc = 0;
                else if (v.setc) mc = 1;
                if (v.br) begin
                    if (v.jt == 2'd0) mz = 0;
                    if (v.jt == 2'd1) mn = 0;
                    if (v.jt == 2'd2) mc = 0;
                end
                if (v.isave) begin
                    if (mstk.size() < 2) mstk.push_back(old);
                    else movf = 1;
                end
            end
        end
    endtask

    initial begin
        vec_t v;
        // r s w mask  alu   sc cc br jt   is rt  ccr     d    o u
        tv.push_back(mk(0,0,1,3'b111,3'b101,0,0,0,2'd0,0,0,4'b0101,2'd0,0,0));
        tv.push_back(mk(0,0,0,3'b000,3'b000,0,0,1,2'd0,0,0,4'b0100,2'd0,0,0));
        tv.push_back(mk(0,0,1,3'b111,3'b011,0,0,0,2'd0,0,0,4'b0011,2'd0,0,0));
        tv.push_back(mk(0,0,1,3'b100,3'b100,1,1,0,2'd0,0,0,4'b0011,2'd0,0,0));
        tv.push_back(mk(0,0,1,3'b111,3'b001,0,0,0,2'd0,0,0,4'b0001,2'd0,0,0));
        tv.push_back(mk(0,0,1,3'b111,3'b110,0,0,0,2'd0,1,0,4'b0110,2'd1,0,0));
        tv.push_back(mk(0,0,0,3'b000,3'b000,0,0,0,2'd0,0,1,4'b0001,2'd0,0,0));
        tv.push_back(mk(0,0,0,3'b000,3'b000,1,0,0,2'd0,1,0,4'b0101,2'd1,0,0));
        tv.push_back(mk(0,0,0,3'b000,3'b000,0,0,1,2'd2,1,0,4'b0001,2'd2,0,0));
        tv.push_back(mk(0,0,1,3'b010,3'b010,0,0,0,2'd0,1,0,4'b0011,2'd2,1,0));
        tv.push_back(mk(0,0,0,3'b000,3'b000,0,0,0,2'd0,0,1,4'b0101,2'd1,1,0));
        tv.push_back(mk(0,0,0,3'b000,3'b000,0,0,0,2'd0,0,1,4'b0001,2'd0,1,0));
        tv.push_back(mk(0,0,1,3'b111,3'b111,1,0,0,2'd0,0,1,4'b0001,2'd0,1,1));
        tv.push_back(mk(0,1,1,3'b111,3'b111,1,0,1,2'd0,1,0,4'b0001,2'd0,1,1));
        tv.push_back(mk(1,1,1,3'b111,3'b111,1,0,0,2'd0,1,0,4'b0000,2'd0,0,0));
        tv.push_back(mk(0,0,1,3'b111,3'b010,0,0,0,2'd0,1,0,4'b0010,2'd1,0,0));
        tv.push_back(mk(0,0,1,3'b111,3'b111,1,0,0,2'd0,1,1,4'b0000,2'd0,0,0));
        tv.push_back(mk(0,0,0,3'b000,3'b000,1,0,0,2'd0,1,0,4'b0100,2'd1,0,0));
        tv.push_back(mk(1,0,0,3'b000,3'b000,0,0,0,2'd0,0,0,4'b0000,2'd0,0,0));
        tv.push_back(mk(0,0,0,3'b000,3'b000,0,0,0,2'd0,0,1,4'b0000,2'd0,0,1));
        tv.push_back(mk(0,0,0,3'b000,3'b000,1,0,1,2'd3,0,0,4'b0100,2'd0,0,1));
        tv.push_back(mk(0,0,1,3'b010,3'b010,0,0,1,2'd1,0,0,4'b0100,2'd0,0,1));
        tv.push_back(mk(0,0,0,3'b111,3'b011,0,0,0,2'd0,0,0,4'b0100,2'd0,0,1));
        tv.push_back(mk(0,0,0,3'b000,3'b000,0,1,0,2'd0,0,0,4'b0000,2'd0,0,1));

        // reset state
        drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_ccr", ccr, 4'b0000);
        chk("reset_depth", depth, 2'd0);
        chk("reset_ovf", ovf_err, 1'b0);
        chk("reset_unf", unf_err, 1'b0);

        // directed table
        foreach (tv[i]) begin
            drive(tv[i]);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ccr", i), ccr, tv[i].e_ccr);
            chk($sformatf("vec%0d_depth", i), depth, tv[i].e_depth);
            chk($sformatf("vec%0d_ovf", i), ovf_err, tv[i].e_ovf);
            chk($sformatf("vec%0d_unf", i), unf_err, tv[i].e_unf);
        end

        // random traffic against the model, starting from reset
        v = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        drive(v);
        model_step(v);
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) begin
            v.rst   = ($urandom_range(0, 39) == 0);
            v.stall = ($urandom_range(0, 5) == 0);
            v.wr    = $urandom_range(0, 1);
            v.mask  = $urandom_range(0, 7);
            v.alu   = $urandom_range(0, 7);
            v.setc  = ($urandom_range(0, 3) == 0);
            v.clrc  = ($urandom_range(0, 3) == 0);
            v.br    = ($urandom_range(0, 2) == 0);
            v.jt    = $urandom_range(0, 3);
            v.isave = ($urandom_range(0, 3) == 0);
            v.rti   = ($urandom_range(0, 4) == 0);
            drive(v);
            model_step(v);
            @(posedge clk); #1;
            chk("rnd_ccr", ccr, {1'b0, mc, mn, mz});
            chk("rnd_depth", depth, mstk.size());
            chk("rnd_ovf", ovf_err, movf);
            chk("rnd_unf", unf_err, munf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
